// File: rtl/cdb_arbiter.sv
// Complete-stage arbiter: one holding slot per functional unit, round-robin
// grant onto a registered common data bus and RS release strobe.
module cdb_arbiter #(
    parameter  int NUM_FU = 5,
    parameter  int PREG_W = 6,
    parameter  int RS_SZ  = 8,
    localparam int IDX_W  = $clog2(RS_SZ),
    localparam int PTR_W  = $clog2(NUM_FU)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_FU-1:0]        fu_done_i,
    input  logic [NUM_FU*PREG_W-1:0] fu_preg_i,
    input  logic [NUM_FU-1:0]        fu_has_dest_i,
    input  logic [NUM_FU*IDX_W-1:0]  fu_rs_idx_i,
    output logic [NUM_FU-1:0]        fu_stall_o,
    output logic                     cdb_valid_o,
    output logic [PREG_W-1:0]        cdb_phys_reg_o,
    output logic                     cdb_ready_o,
    output logic [IDX_W-1:0]         remove_idx_o,
    output logic                     remove_en_o
);

    logic [NUM_FU-1:0] slot_valid;
    logic [PREG_W-1:0] slot_preg [NUM_FU];
    logic              slot_dest [NUM_FU];
    logic [IDX_W-1:0]  slot_idx  [NUM_FU];

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    cand;

    logic              cdb_valid_q, cdb_valid_d;
    logic [PREG_W-1:0] phys_reg_q, phys_reg_d;
    logic              remove_en_q, remove_en_d;
    logic [IDX_W-1:0]  remove_idx_q, remove_idx_d;

    // Rotating priority: first valid slot at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_FU))
                cand = cand - (PTR_W+1)'(NUM_FU);
            if (!grant_any && slot_valid[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
        logic              valid_q, valid_d;
        logic              dest_q, dest_d;
        logic [PREG_W-1:0] preg_q, preg_d;
        logic [IDX_W-1:0]  idx_q, idx_d;
        logic              hit;
        logic              accept;

        assign hit           = grant_any && (grant_idx == PTR_W'(i));
        assign fu_stall_o[i] = valid_q && !hit;
        assign accept        = fu_done_i[i] && !fu_stall_o[i];

        // A reload in the grant cycle wins over the clear: no bubble.
        always_comb begin
            valid_d = valid_q;
            dest_d  = dest_q;
            preg_d  = preg_q;
            idx_d   = idx_q;
            if (hit)
                valid_d = 1'b0;
            if (accept) begin
                valid_d = 1'b1;
                dest_d  = fu_has_dest_i[i];
                preg_d  = fu_preg_i[i*PREG_W +: PREG_W];
                idx_d   = fu_rs_idx_i[i*IDX_W +: IDX_W];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                valid_q <= 1'b0;
                dest_q  <= 1'b0;
                preg_q  <= '0;
                idx_q   <= '0;
            end else begin
                valid_q <= valid_d;
                dest_q  <= dest_d;
                preg_q  <= preg_d;
                idx_q   <= idx_d;
            end
        end

        assign slot_valid[i] = valid_q;
        assign slot_dest[i]  = dest_q;
        assign slot_preg[i]  = preg_q;
        assign slot_idx[i]   = idx_q;
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        remove_en_d  = grant_any;
        cdb_valid_d  = 1'b0;
        phys_reg_d   = phys_reg_q;
        remove_idx_d = remove_idx_q;
        if (grant_any) begin
            rr_ptr_d     = (grant_idx == PTR_W'(NUM_FU-1)) ? '0
                                                           : grant_idx + 1'b1;
            cdb_valid_d  = slot_dest[grant_idx];
            phys_reg_d   = slot_preg[grant_idx];
            remove_idx_d = slot_idx[grant_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            phys_reg_q   <= '0;
            remove_en_q  <= 1'b0;
            remove_idx_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            phys_reg_q   <= phys_reg_d;
            remove_en_q  <= remove_en_d;
            remove_idx_q <= remove_idx_d;
        end
    end

    assign cdb_valid_o    = cdb_valid_q;
    assign cdb_ready_o    = cdb_valid_q;
    assign cdb_phys_reg_o = phys_reg_q;
    assign remove_en_o    = remove_en_q;
    assign remove_idx_o   = remove_idx_q;

endmodule
